instr_fetch_queue: RTL and testbench

- Front-end fetch stage that sits between the clocked instruction memory and the IF/ID pipeline register.
- Generates sequential fetch addresses and buffers returned instructions, each tagged with its PC, in a small FIFO.
- Presents the FIFO head to the decode stage with a valid/ready handshake.
- Handles stalls (hazard unit) and branch/jump redirects (flush) so decode never sees wrong-path instructions.

---
 rtl/instr_fetch_queue.sv | 87 ++++++++
 tb/tb_instr_fetch_queue.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_queue.sv
// Fetch front end: issues sequential instruction-memory requests and queues
// {pc, instr} pairs for decode behind a valid/ready handshake, with flush on redirect.
module instr_fetch_queue #(
  parameter int PC_W     = 9,
  parameter int INS_W    = 32,
  parameter int DEPTH    = 4,
  parameter int RESET_PC = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic                       imem_req,
  output logic [PC_W-1:0]            imem_addr,
  input  logic [INS_W-1:0]           imem_rdata,
  input  logic                       redirect,
  input  logic [PC_W-1:0]            redirect_pc,
  output logic                       out_valid,
  output logic [PC_W-1:0]            out_pc,
  output logic [INS_W-1:0]           out_instr,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     occupancy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [PC_W-1:0]  pc;
    logic [INS_W-1:0] instr;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [PC_W-1:0] fetch_pc, inflight_pc;
  logic [AW-1:0]   head, tail;
  logic [CW-1:0]   count;
  logic            inflight;
  logic [CW:0]     pending;
  logic            issue, push, pop;

  // An outstanding request reserves a slot so the returning word always fits.
  assign pending   = {1'b0, count} + {{CW{1'b0}}, inflight};
  assign issue     = reset && !redirect && (pending < (CW+1)'(DEPTH));
  assign push      = inflight && !redirect;
  assign pop       = out_valid && out_ready && !redirect;

  assign imem_req  = issue;
  assign imem_addr = fetch_pc;
  assign out_valid = (count != '0);
  assign out_pc    = out_valid ? mem[head].pc    : '0;
  assign out_instr = out_valid ? mem[head].instr : '0;
  assign occupancy = count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc    <= PC_W'(RESET_PC);
      inflight_pc <= '0;
      inflight    <= 1'b0;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
    end else if (redirect) begin
      fetch_pc <= {redirect_pc[PC_W-1:2], 2'b00};
      inflight <= 1'b0;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_pc <= fetch_pc;
        fetch_pc    <= fetch_pc + PC_W'(4);
      end
      if (push) tail <= tail + AW'(1);
      if (pop)  head <= head + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; count gates visibility of every entry.
  always_ff @(posedge clk) begin
    if (reset && push) mem[tail] <= '{pc: inflight_pc, instr: imem_rdata};
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue: startup, stall/backpressure, redirect,
// PC wrap and asynchronous reset, against hand-computed values.
module tb_instr_fetch_queue;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [8:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [8:0]  redirect_pc;
  logic        out_valid;
  logic [8:0]  out_pc;
  logic [31:0] out_instr;
  logic        out_ready;
  logic [2:0]  occupancy;

  int checks = 0;
  int errors = 0;

  instr_fetch_queue #(.PC_W(9), .INS_W(32), .DEPTH(4), .RESET_PC(0)) dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .redirect(redirect), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr),
    .out_ready(out_ready), .occupancy(occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Clocked instruction memory: word = address | 0xA000_0000, one cycle later.
  always @(posedge clk) imem_rdata <= 32'hA000_0000 | {23'd0, imem_addr};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (got timeout, need $finish)");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    reset = 1'b0; redirect = 1'b0; redirect_pc = '0; out_ready = 1'b1;
    tick(); tick();
    // reset state
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_req",   32'(imem_req),  0);
    chk("rst_occ",   32'(occupancy), 0);
    chk("rst_pc",    32'(out_pc),    0);
    chk("rst_instr", out_instr,      0);

    // startup streaming
    reset = 1'b1; #1;
    chk("s1_req0",  32'(imem_req),  1);
    chk("s1_addr0", 32'(imem_addr), 0);
    chk("s1_val0",  32'(out_valid), 0);
    tick();
    chk("s1_addr1", 32'(imem_addr), 4);
    chk("s1_val1",  32'(out_valid), 0);
    tick();
    chk("s1_addr2", 32'(imem_addr), 8);
    chk("s1_val2",  32'(out_valid), 1);
    chk("s1_pc2",   32'(out_pc),    0);
    chk("s1_ins2",  out_instr,      32'hA000_0000);
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk("s1_val", 32'(out_valid), 1);
      chk("s1_pc",  32'(out_pc),    32'(4*i));
      chk("s1_ins", out_instr,      32'hA000_0000 | 32'(4*i));
    end

    // stall from the start
    @(posedge clk); #1;
    reset = 1'b0; out_ready = 1'b0;
    tick();
    reset = 1'b1; #1;
    for (int i = 0; i < 5; i++) begin
      chk("s2_fillpc", 32'(out_pc), 0);
      tick();
    end
    chk("s2_occ",   32'(occupancy), 4);
    chk("s2_req",   32'(imem_req),  0);
    tick();
    chk("s2_occ_b", 32'(occupancy), 4);
    chk("s2_req_b", 32'(imem_req),  0);
    chk("s2_pc_b",  32'(out_pc),    0);
    tick();
    out_ready = 1'b1; #1;
    chk("s2_pc0", 32'(out_pc), 0);
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk("s2_val", 32'(out_valid), 1);
      chk("s2_pc",  32'(out_pc),    32'(4*i));
      chk("s2_ins", out_instr,      32'hA000_0000 | 32'(4*i));
    end

    // redirect while streaming at 0x20
    n = 0;
    while (!(out_valid && out_pc == 9'h20) && n < 50) begin
      tick();
      n++;
    end
    chk("s3_reach20", 32'(out_valid && out_pc == 9'h20), 1);
    redirect = 1'b1; redirect_pc = 9'h103; #1;
    chk("s3_req_R", 32'(imem_req), 0);
    tick();
    redirect = 1'b0; #1;
    chk("s3_val1",  32'(out_valid), 0);
    chk("s3_addr1", 32'(imem_addr), 32'h100);
    chk("s3_req1",  32'(imem_req),  1);
    tick();
    chk("s3_val2",  32'(out_valid), 0);
    chk("s3_addr2", 32'(imem_addr), 32'h104);
    tick();
    chk("s3_val3",  32'(out_valid), 1);
    chk("s3_pc3",   32'(out_pc),    32'h100);
    chk("s3_ins3",  out_instr,      32'hA000_0100);
    tick();
    chk("s3_pc4",   32'(out_pc),    32'h104);

    // redirect colliding with a returning response and a pop
    chk("s4_occ_pre", 32'(occupancy), 1);
    chk("s4_val_pre", 32'(out_valid), 1);
    redirect = 1'b1; redirect_pc = 9'h1F8;
    tick();
    redirect = 1'b0; #1;
    chk("s4_occ",  32'(occupancy), 0);
    chk("s4_val",  32'(out_valid), 0);
    chk("s5_addr0", 32'(imem_addr), 32'h1F8);
    tick();
    chk("s4_occ2", 32'(occupancy), 0);
    chk("s5_addr1", 32'(imem_addr), 32'h1FC);
    tick();
    chk("s5_addr2", 32'(imem_addr), 32'h000);
    chk("s5_pc0",  32'(out_pc), 32'h1F8);
    tick();
    chk("s5_pc1",  32'(out_pc), 32'h1FC);
    tick();
    chk("s5_pc2",  32'(out_pc), 32'h000);
    chk("s5_ins2", out_instr,   32'hA000_0000);
    tick();
    chk("s5_pc3",  32'(out_pc), 32'h004);

    // async reset with three entries queued
    out_ready = 1'b0;
    tick(); tick();
    chk("s6_occ3", 32'(occupancy), 3);
    chk("s6_val",  32'(out_valid), 1);
    #2;
    reset = 1'b0;
    #1;
    chk("s6_async_val", 32'(out_valid), 0);
    chk("s6_async_req", 32'(imem_req),  0);
    chk("s6_async_occ", 32'(occupancy), 0);
    tick();
    reset = 1'b1; out_ready = 1'b1; #1;
    chk("s6_req",  32'(imem_req),  1);
    chk("s6_addr", 32'(imem_addr), 0);
    tick();
    chk("s6_val1", 32'(out_valid), 0);
    tick();
    chk("s6_val2", 32'(out_valid), 1);
    chk("s6_pc2",  32'(out_pc),    0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
